gcm_decrypt_release_buffer: RTL and testbench

GCM_DECRYPT_RELEASE_BUFFER -- requirements
Module: gcm_decrypt_release_buffer

---
 rtl/gcm_decrypt_release_buffer.sv | 159 +++++++++++++++
 tb/tb_gcm_decrypt_release_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_decrypt_release_buffer.sv
// gcm_decrypt_release_buffer
//
// Holds decrypted GCM plaintext in a DEPTH-entry FIFO until the instance's
// authentication tag has been checked. Plaintext is released downstream only
// after a tag match; on mismatch or FIFO overflow the buffered plaintext is
// discarded and a single auth-fail pulse is raised.
//
// Optional feature: define GCM_TRUNC_TAG_EN to honour i_tag96 (compare only
// tag bits [0:95] when the latched i_tag96 is 1). Without the macro i_tag96 is
// ignored and the full 128-bit tag is compared.
//
// Ports:
//   clk, i_rst_n                     clock, async active-low reset
//   i_pt_valid/i_pt_data/i_pt_last   plaintext block input
//   o_pt_ready                       input handshake (high in FILL and ABORT)
//   i_tag_valid/i_calc_tag/i_rx_tag  tag pair (one-cycle pulse)
//   i_tag96                          truncated-tag compare request
//   o_out_valid/o_out_data/o_out_last, i_out_ready   released plaintext stream
//   o_auth_pass/o_auth_fail          one-cycle authentication result pulses
//
// Parameter: DEPTH  FIFO depth in 128-bit blocks (power of two).

module gcm_decrypt_release_buffer #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_pt_valid,
    input  logic [0:127] i_pt_data,
    input  logic         i_pt_last,
    output logic         o_pt_ready,
    input  logic         i_tag_valid,
    input  logic [0:127] i_calc_tag,
    input  logic [0:127] i_rx_tag,
    input  logic         i_tag96,
    output logic         o_out_valid,
    output logic [0:127] o_out_data,
    output logic         o_out_last,
    input  logic         i_out_ready,
    output logic         o_auth_pass,
    output logic         o_auth_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        FILL, WAIT_TAG, CHECK, RELEASE, DISCARD, ABORT
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            tag_held;
    logic            fail_done;   // fail already pulsed in CHECK for this instance
    logic            rst_done;    // keeps o_pt_ready low until the first edge after reset
    logic [0:127]    calc_q, rx_q;
    logic [0:127]    mem [DEPTH];

    logic pt_accept, full, wr_en, pop, tag_load, tag_clr, tag_match;

    assign pt_accept = o_pt_ready && i_pt_valid;
    assign full      = (count == CW'(DEPTH));
    assign wr_en     = pt_accept && (state == FILL) && !full;
    assign pop       = o_out_valid && i_out_ready;
    assign tag_load  = i_tag_valid && !tag_held &&
                       (state == FILL || state == WAIT_TAG || state == ABORT);
    assign tag_clr   = (state != state_nxt) &&
                       (state == CHECK || state == DISCARD || state == ABORT);

`ifdef GCM_TRUNC_TAG_EN
    logic tag96_q;
    assign tag_match = tag96_q ? (calc_q[0:95] == rx_q[0:95]) : (calc_q == rx_q);
`else
    logic unused_tag96;
    assign unused_tag96 = i_tag96;
    assign tag_match    = (calc_q == rx_q);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (pt_accept) begin
                    if (full)
                        state_nxt = i_pt_last ? DISCARD : ABORT;
                    else if (i_pt_last)
                        // a tag arriving with the last block still counts as held
                        state_nxt = (tag_held || i_tag_valid) ? CHECK : WAIT_TAG;
                end
            end
            WAIT_TAG: if (tag_held || i_tag_valid) state_nxt = CHECK;
            CHECK: begin
                if (!tag_match)       state_nxt = DISCARD;
                else if (count == '0) state_nxt = FILL;
                else                  state_nxt = RELEASE;
            end
            RELEASE: if (pop && count == CW'(1)) state_nxt = FILL;
            DISCARD: state_nxt = FILL;
            ABORT:   if (pt_accept && i_pt_last) state_nxt = DISCARD;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        o_pt_ready  = rst_done && (state == FILL || state == ABORT);
        o_out_valid = (state == RELEASE);
        o_out_data  = o_out_valid ? mem[rd_ptr] : '0;
        o_out_last  = o_out_valid && (count == CW'(1));
        o_auth_pass = (state == CHECK) && tag_match;
        o_auth_fail = ((state == CHECK) && !tag_match) ||
                      ((state == DISCARD) && !fail_done);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FILL;
            rst_done  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tag_held  <= 1'b0;
            fail_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;

            if (tag_load) tag_held <= 1'b1;
            if (tag_clr)  tag_held <= 1'b0;

            if (state == DISCARD)                    fail_done <= 1'b0;
            else if (state == CHECK && !tag_match)   fail_done <= 1'b1;

            if (state == DISCARD) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                if (wr_en)    count <= count + 1'b1;
                else if (pop) count <= count - 1'b1;
            end
        end
    end

    // Data storage carries no reset; validity is tracked by count and tag_held.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= i_pt_data;
        if (tag_load) begin
            calc_q <= i_calc_tag;
            rx_q   <= i_rx_tag;
`ifdef GCM_TRUNC_TAG_EN
            tag96_q <= i_tag96;
`endif
        end
    end

endmodule

// File: tb/tb_gcm_decrypt_release_buffer.sv
module tb_gcm_decrypt_release_buffer;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_pt_valid;
    logic [0:127] i_pt_data;
    logic         i_pt_last;
    logic         o_pt_ready;
    logic         i_tag_valid;
    logic [0:127] i_calc_tag;
    logic [0:127] i_rx_tag;
    logic         i_tag96;
    logic         o_out_valid;
    logic [0:127] o_out_data;
    logic         o_out_last;
    logic         i_out_ready;
    logic         o_auth_pass;
    logic         o_auth_fail;

    gcm_decrypt_release_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_pt_valid(i_pt_valid), .i_pt_data(i_pt_data), .i_pt_last(i_pt_last),
        .o_pt_ready(o_pt_ready),
        .i_tag_valid(i_tag_valid), .i_calc_tag(i_calc_tag), .i_rx_tag(i_rx_tag),
        .i_tag96(i_tag96),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .i_out_ready(i_out_ready),
        .o_auth_pass(o_auth_pass), .o_auth_fail(o_auth_fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    int           n_pass = 0, n_fail = 0, n_both = 0, n_valid = 0, n_idle_bad = 0;
    logic [0:127] out_q[$];
    logic         last_q[$];

    always @(negedge clk) begin
        if (o_auth_pass) n_pass++;
        if (o_auth_fail) n_fail++;
        if (o_auth_pass && o_auth_fail) n_both++;
        if (o_out_valid) begin
            n_valid++;
            if (i_out_ready) begin
                out_q.push_back(o_out_data);
                last_q.push_back(o_out_last);
            end
        end else if (o_out_data !== '0 || o_out_last !== 1'b0) begin
            n_idle_bad++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: an instance authenticates iff it fit in the buffer and its
    // tags agree on the compared bits; a passing instance emits every block in
    // order with last on the final one, a failing one emits nothing.
    function automatic bit model_pass(int n, logic [0:127] c, logic [0:127] r, logic t96);
        bit trunc = 1'b0;
`ifdef GCM_TRUNC_TAG_EN
        trunc = 1'b1;
`endif
        if (n > DEPTH) return 1'b0;
        if (trunc && t96) return c[0:95] == r[0:95];
        return c == r;
    endfunction

    logic [0:127] blk[$];

    task automatic check_outs(input string nm, input bit exp_pass, input int p0, input int f0,
                              input int b0, input int v0, input int i0, input int q0);
        int nout;
        nout = exp_pass ? blk.size() : 0;
        chk({nm, "_pass_cnt"}, 128'(n_pass - p0), 128'(exp_pass ? 1 : 0));
        chk({nm, "_fail_cnt"}, 128'(n_fail - f0), 128'(exp_pass ? 0 : 1));
        chk({nm, "_both"},     128'(n_both - b0), 128'(0));
        chk({nm, "_idle_zero"}, 128'(n_idle_bad - i0), 128'(0));
        chk({nm, "_pops"},     128'(out_q.size() - q0), 128'(nout));
        if (!exp_pass) chk({nm, "_no_valid"}, 128'(n_valid - v0), 128'(0));
        for (int k = 0; k < nout && q0 + k < out_q.size(); k++) begin
            chk($sformatf("%s_data%0d", nm, k), out_q[q0 + k], blk[k]);
            chk($sformatf("%s_last%0d", nm, k), 128'(last_q[q0 + k]), 128'(k == nout - 1));
        end
        chk({nm, "_count0"}, 128'(dut.count), 128'(0));
    endtask

    // Sends blk[] as one instance. tag_at = index of the block the tag pulse
    // accompanies, or blk.size() for a pulse after the last block.
    task automatic run_inst(input string nm, input logic [0:127] calc, input logic [0:127] rx,
                            input logic t96, input int tag_at, input bit rnd_ready);
        int  p0, f0, b0, v0, i0, q0, n, cyc;
        bit  exp_pass;
        n = blk.size();
        exp_pass = model_pass(n, calc, rx, t96);
        p0 = n_pass; f0 = n_fail; b0 = n_both; v0 = n_valid; i0 = n_idle_bad; q0 = out_q.size();
        cyc = 0;
        while (!o_pt_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk({nm, "_start_ready"}, 128'(o_pt_ready), 128'(1));
        i_calc_tag = calc; i_rx_tag = rx; i_tag96 = t96;
        for (int i = 0; i < n; i++) begin
            i_pt_valid = 1'b1; i_pt_data = blk[i]; i_pt_last = (i == n - 1);
            i_tag_valid = (i == tag_at);
            chk($sformatf("%s_ready_blk%0d", nm, i), 128'(o_pt_ready), 128'(1));
            @(posedge clk); #1;
            i_tag_valid = 1'b0;
            if (n > DEPTH && i == DEPTH)
                chk({nm, "_ovf_count"}, 128'(dut.count), 128'(DEPTH));
        end
        i_pt_valid = 1'b0; i_pt_last = 1'b0; i_pt_data = '0;
        if (tag_at >= n) begin
            i_tag_valid = 1'b1; @(posedge clk); #1; i_tag_valid = 1'b0;
        end
        cyc = 0;
        while (!((n_pass + n_fail > p0 + f0) && o_pt_ready && !o_out_valid) && cyc < 400) begin
            if (rnd_ready) i_out_ready = 1'($urandom % 2);
            @(posedge clk); #1; cyc++;
        end
        i_out_ready = 1'b1;
        chk({nm, "_done"}, 128'(cyc < 400), 128'(1));
        @(negedge clk); #1;
        check_outs(nm, exp_pass, p0, f0, b0, v0, i0, q0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pt_ready"}, 128'(o_pt_ready), 128'(0));
        chk({nm, "_out_valid"}, 128'(o_out_valid), 128'(0));
        chk({nm, "_out_data"}, o_out_data, 128'(0));
        chk({nm, "_out_last"}, 128'(o_out_last), 128'(0));
        chk({nm, "_pass"}, 128'(o_auth_pass), 128'(0));
        chk({nm, "_fail"}, 128'(o_auth_fail), 128'(0));
    endtask

    initial begin
        logic [0:127] ta, tb2;
        int p0, f0, b0, v0, i0, q0, cyc, n, tag_at;

        i_rst_n = 1'b0; i_pt_valid = 1'b0; i_pt_data = '0; i_pt_last = 1'b0;
        i_tag_valid = 1'b0; i_calc_tag = '0; i_rx_tag = '0; i_tag96 = 1'b0;
        i_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        #1;
        chk("reset_ready_still_low", 128'(o_pt_ready), 128'(0));
        @(posedge clk); #1;
        chk("reset_ready_rises", 128'(o_pt_ready), 128'(1));

        // Pass case
        ta = {16{8'hA5}};
        blk = {128'd1, 128'd2, 128'd3};
        run_inst("pass", ta, ta, 1'b0, 3, 1'b0);

        // Fail case: bit 127 differs
        tb2 = ta; tb2[127] = ~tb2[127];
        run_inst("fail", ta, tb2, 1'b0, 3, 1'b0);

        // Overflow: 17 blocks fill and overflow, the 18th carries last
        blk.delete();
        for (int i = 0; i < DEPTH + 2; i++) blk.push_back(128'(i + 100));
        run_inst("ovf", ta, ta, 1'b0, 5, 1'b0);

        // Overflow where the 17th block itself carries last
        blk.delete();
        for (int i = 0; i < DEPTH + 1; i++) blk.push_back(128'(i + 200));
        run_inst("ovf_last", ta, ta, 1'b0, 2, 1'b0);

        // Tag with last in the same cycle, backpressure 1,0,0,1 during release
        blk = {128'h11, 128'h22, 128'h33};
        p0 = n_pass; f0 = n_fail; b0 = n_both; v0 = n_valid; i0 = n_idle_bad; q0 = out_q.size();
        i_calc_tag = ta; i_rx_tag = ta; i_tag96 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_pt_valid = 1'b1; i_pt_data = blk[i]; i_pt_last = (i == 2); i_tag_valid = (i == 2);
            @(posedge clk); #1;
        end
        i_pt_valid = 1'b0; i_pt_last = 1'b0; i_tag_valid = 1'b0; i_pt_data = '0;
        chk("bp_check_next_cycle", 128'(o_auth_pass), 128'(1));
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        chk("bp_head0", o_out_data, blk[0]);
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        chk("bp_head1", o_out_data, blk[1]);
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        chk("bp_stall_data", o_out_data, blk[1]);
        chk("bp_stall_valid", 128'(o_out_valid), 128'(1));
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        chk("bp_stall_data2", o_out_data, blk[1]);
        @(posedge clk); #1;
        chk("bp_head2", o_out_data, blk[2]);
        chk("bp_last", 128'(o_out_last), 128'(1));
        @(posedge clk); #1;
        chk("bp_idle", 128'(o_out_valid), 128'(0));
        @(negedge clk); #1;
        check_outs("bp", 1'b1, p0, f0, b0, v0, i0, q0);

        // Truncated tag: differ only in bit 100
        ta = {$urandom, $urandom, $urandom, $urandom};
        tb2 = ta; tb2[100] = ~tb2[100];
        blk = {128'hABCD};
        run_inst("trunc96", ta, tb2, 1'b1, 1, 1'b0);
        tb2 = ta; tb2[50] = ~tb2[50];
        run_inst("trunc96_hi", ta, tb2, 1'b1, 0, 1'b0);

        // Reset mid-release after one pop
        blk = {128'h71, 128'h72, 128'h73};
        ta = {16{8'h3C}};
        i_calc_tag = ta; i_rx_tag = ta; i_tag96 = 1'b0; i_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_pt_valid = 1'b1; i_pt_data = blk[i]; i_pt_last = (i == 2); i_tag_valid = (i == 2);
            @(posedge clk); #1;
        end
        i_pt_valid = 1'b0; i_pt_last = 1'b0; i_tag_valid = 1'b0; i_pt_data = '0;
        cyc = 0;
        while (!o_out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("rst_release_reached", 128'(o_out_valid), 128'(1));
        @(posedge clk); #1;
        chk("rst_after_pop", o_out_data, blk[1]);
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready_low", 128'(o_pt_ready), 128'(0));
        @(posedge clk); #1;
        chk("rst_ready_high", 128'(o_pt_ready), 128'(1));
        chk("rst_no_resume", 128'(o_out_valid), 128'(0));
        blk = {128'h99};
        run_inst("rst_fresh", ta, ta, 1'b0, 1, 1'b0);

        // Randomized instances against the reference model
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, DEPTH + 3);
            blk.delete();
            for (int i = 0; i < n; i++) blk.push_back({$urandom, $urandom, $urandom, $urandom});
            ta = {$urandom, $urandom, $urandom, $urandom};
            tb2 = ta;
            if ($urandom % 2) tb2[$urandom_range(0, 127)] ^= 1'b1;
            tag_at = (n > DEPTH) ? $urandom_range(0, n - 1) : $urandom_range(0, n);
            run_inst($sformatf("rnd%0d", t), ta, tb2, 1'($urandom % 2), tag_at, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
